nv_ram_rwsp_fifo_ctrl: RTL and testbench

//  Valid/ready FIFO controller driving one external rwsp RAM (write port wa/we/di; read port ra/re/ore/dout).

---
 rtl/nv_rwsp_pkg.sv | 17 +
 rtl/nv_rwsp_updn_cnt.sv | 34 +++
 rtl/nv_ram_rwsp_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_nv_ram_rwsp_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nv_rwsp_pkg.sv
// Shared constants and elaboration helpers for the rwsp RAM FIFO controller.
package nv_rwsp_pkg;

    localparam int NV_RWSP_WIDTH = 65;
    localparam int NV_RWSP_DEPTH = 8;
    localparam int NV_RWSP_AW    = 3;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    // True when the address width really is log2 of the depth.
    function automatic bit aw_matches(input int depth, input int aw);
        return $clog2(depth) == aw;
    endfunction

endpackage

// File: rtl/nv_rwsp_updn_cnt.sv
// Saturation-free up/down occupancy counter; simultaneous inc and dec cancel.
module nv_rwsp_updn_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// Valid/ready FIFO controller around an external 2-stage-read RAM; accept->rd_valid is 3 cycles.
// Backpressure: rd_ready low freezes the output reg and s1; wr_ready depends only on registered state.
module nv_ram_rwsp_fifo_ctrl
    import nv_rwsp_pkg::*;
#(
    parameter int WIDTH = NV_RWSP_WIDTH,
    parameter int DEPTH = NV_RWSP_DEPTH,
    parameter int AW    = NV_RWSP_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [31:0]      ram_pd,
    output logic [AW:0]      fifo_cnt,
    output logic             idle
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          s1_vld_q, s1_vld_d;
    logic          s2_vld_q, s2_vld_d;
    logic [AW:0]   used;
    logic [AW:0]   unread;

    // A slot is released only when its data leaves the RAM array (ore), not at re.
    nv_rwsp_updn_cnt #(.W(AW+1)) u_used (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ram_we),
        .dec_i (ram_ore),
        .cnt_o (used)
    );

    nv_rwsp_updn_cnt #(.W(AW+1)) u_unread (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ram_we),
        .dec_i (ram_re),
        .cnt_o (unread)
    );

    always_comb begin
        wr_ready = !rst && (used < DEPTH_C);
        ram_we   = wr_valid && wr_ready;
        ram_ore  = !rst && s1_vld_q && (!s2_vld_q || rd_ready);
        ram_re   = !rst && (unread != '0) && (!s1_vld_q || ram_ore);
        rd_valid = !rst && s2_vld_q;
        fifo_cnt = rst ? '0 : used;
        idle     = rst || ((used == '0) && !s1_vld_q && !s2_vld_q);

        wr_ptr_d = ram_we ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = ram_re ? rd_ptr_q + AW'(1) : rd_ptr_q;
        s1_vld_d = ram_re  || (s1_vld_q && !ram_ore);
        s2_vld_d = ram_ore || (s2_vld_q && !rd_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    assign ram_wa = wr_ptr_q;
    assign ram_ra = rd_ptr_q;
    assign ram_di = wr_pd;
    assign rd_pd  = ram_dout;
    assign ram_pd = 32'd0;

    // Occupied slots are the `used` entries behind wr_ptr, so a write is safe only below DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (is_pow2(DEPTH) && aw_matches(DEPTH, AW));
            assert (used <= DEPTH_C);
            assert (unread <= used);
            assert (!ram_we || (used < DEPTH_C));
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// Directed plus random bench for nv_ram_rwsp_fifo_ctrl with a behavioural RAM and queue model.
module tb_nv_ram_rwsp_fifo_ctrl;

    localparam int W = 65;
    localparam int D = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid, wr_ready, rd_valid, rd_ready;
    logic [W-1:0] wr_pd, rd_pd, ram_di, ram_dout;
    logic         ram_we, ram_re, ram_ore, idle;
    logic [A-1:0] ram_wa, ram_ra;
    logic [31:0]  ram_pd;
    logic [A:0]   fifo_cnt;

    always #5 clk = ~clk;

    nv_ram_rwsp_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pd(wr_pd),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pd(rd_pd),
        .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
        .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
        .ram_dout(ram_dout), .ram_pd(ram_pd),
        .fifo_cnt(fifo_cnt), .idle(idle)
    );

    // Behavioural rwsp RAM: re latches the address, ore loads the output register.
    logic [W-1:0] mem [D];
    logic [A-1:0] ra_d;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_d <= ram_ra;
        if (ram_ore) ram_dout <= mem[ra_d];
    end

    int errors = 0;
    int checks = 0;

    // Reference model: payload queue in order, entries not yet fetched, and the two read stages.
    logic [W-1:0] q[$];
    int  n_ram = 0;
    bit  m_s1 = 0, m_s2 = 0;
    int  m_wp = 0, m_rp = 0;
    int  acc = 0, took = 0, cyc = 0;

    bit           s_rv, s_wrdy, s_idle, s_take;
    logic [A:0]   s_cnt;
    logic [A-1:0] s_wa;
    logic [W-1:0] s_pd;
    bit           prev_stall = 0;
    logic [W-1:0] prev_pd;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit e_wrdy, e_we, e_re, e_ore, e_rv, e_idle;
        int used;
        @(negedge clk);
        used = n_ram + int'(m_s1);
        if (rst) begin
            e_wrdy = 0; e_we = 0; e_re = 0; e_ore = 0; e_rv = 0; e_idle = 1; used = 0;
        end else begin
            e_wrdy = used < D;
            e_we   = wr_valid && e_wrdy;
            e_ore  = m_s1 && (!m_s2 || rd_ready);
            e_re   = (n_ram > 0) && (!m_s1 || e_ore);
            e_rv   = m_s2;
            e_idle = (used == 0) && !m_s1 && !m_s2;
        end
        chk("wr_ready", W'(wr_ready), W'(e_wrdy));
        chk("rd_valid", W'(rd_valid), W'(e_rv));
        chk("ram_we",   W'(ram_we),   W'(e_we));
        chk("ram_re",   W'(ram_re),   W'(e_re));
        chk("ram_ore",  W'(ram_ore),  W'(e_ore));
        chk("fifo_cnt", W'(fifo_cnt), W'(used));
        chk("idle",     W'(idle),     W'(e_idle));
        chk("ram_pd",   W'(ram_pd),   '0);
        if (e_we) begin
            chk("ram_wa", W'(ram_wa), W'(m_wp));
            chk("ram_di", ram_di, wr_pd);
        end
        if (e_re) chk("ram_ra", W'(ram_ra), W'(m_rp));
        if (e_rv) chk("rd_pd", rd_pd, q[0]);
        if (prev_stall && !rst) chk("rd_pd_stall", rd_pd, prev_pd);
        s_rv = rd_valid; s_wrdy = wr_ready; s_idle = idle; s_cnt = fifo_cnt;
        s_wa = ram_wa; s_pd = rd_pd; s_take = rd_valid && rd_ready;
        prev_stall = !rst && rd_valid && !rd_ready;
        prev_pd = rd_pd;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete(); n_ram = 0; m_s1 = 0; m_s2 = 0; m_wp = 0; m_rp = 0;
        end else begin
            if (m_s2 && rd_ready) begin
                void'(q.pop_front());
                took++;
            end
            if (e_we) begin
                q.push_back(wr_pd); n_ram++; m_wp = (m_wp + 1) % D; acc++;
            end
            if (e_re) begin
                n_ram--; m_rp = (m_rp + 1) % D;
            end
            m_s2 = e_ore || (m_s2 && !rd_ready);
            m_s1 = e_re || (m_s1 && !e_ore);
        end
        #1;
    endtask

    initial begin
        int t_rv, a0, k0, first_take, last_take;
        logic [W-1:0] got;
        rst = 1; wr_valid = 0; rd_ready = 0; wr_pd = '0;
        cycle(); cycle();
        rst = 0;
        cycle();

        // 1: single word latency and data
        wr_valid = 1; rd_ready = 1; wr_pd = 65'h1_DEAD_BEEF_0000_0001;
        cycle();
        wr_valid = 0; wr_pd = '0;
        t_rv = -1; got = '0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (s_rv && t_rv < 0) begin
                t_rv = k; got = s_pd;
            end
        end
        chk("t1_latency", W'(t_rv), W'(3));
        chk("t1_data", got, 65'h1_DEAD_BEEF_0000_0001);
        chk("t1_idle", W'(s_idle), W'(1));

        // 2: fill with consumer stalled; RAM holds DEPTH plus one word in the output reg
        a0 = acc; k0 = took;
        wr_valid = 1; rd_ready = 0;
        for (int k = 0; k < 12; k++) begin
            wr_pd = W'(acc - a0);
            cycle();
        end
        chk("t2_accepted", W'(acc - a0), W'(D + 1));
        chk("t2_cnt_full", W'(s_cnt), W'(D));
        chk("t2_wr_ready", W'(s_wrdy), W'(0));
        wr_valid = 0; rd_ready = 1;
        for (int k = 0; k < 14; k++) cycle();
        chk("t2_drained", W'(took - k0), W'(D + 1));

        // 3: streaming 100 words, one per cycle with no gaps
        a0 = acc; k0 = took; first_take = -1; last_take = -1;
        wr_valid = 1; rd_ready = 1;
        for (int k = 0; k < 300 && (took - k0) < 100; k++) begin
            wr_valid = (acc - a0) < 100;
            wr_pd = W'(acc - a0);
            cycle();
            if (s_take) begin
                if (first_take < 0) first_take = cyc;
                last_take = cyc;
            end
        end
        wr_valid = 0;
        chk("t3_count", W'(took - k0), W'(100));
        chk("t3_no_gaps", W'(last_take - first_take), W'(99));

        // 4: random consumer backpressure with continuous writes
        k0 = took; a0 = acc;
        for (int k = 0; k < 200; k++) begin
            wr_valid = 1;
            wr_pd = {$urandom, $urandom, $urandom} & {W{1'b1}};
            rd_ready = $urandom_range(0, 1) == 1;
            cycle();
        end
        wr_valid = 0; rd_ready = 1;
        for (int k = 0; k < 20; k++) cycle();
        chk("t4_all_out", W'(took - k0), W'(acc - a0));

        // 5: reset mid-stream discards contents
        a0 = acc; rd_ready = 0; wr_valid = 1;
        for (int k = 0; k < 20 && (acc - a0) < 5; k++) begin
            wr_pd = W'(32'hA000 + acc - a0);
            cycle();
        end
        wr_valid = 0;
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        chk("t5_rd_valid", W'(s_rv), W'(0));
        chk("t5_cnt", W'(s_cnt), W'(0));
        chk("t5_idle", W'(s_idle), W'(1));
        k0 = took;
        wr_valid = 1; rd_ready = 1; wr_pd = 65'h0_5555_AAAA_1234_5678;
        cycle();
        chk("t5_wa", W'(s_wa), W'(0));
        wr_valid = 0;
        got = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (s_take) got = s_pd;
        end
        chk("t5_readback_n", W'(took - k0), W'(1));
        chk("t5_readback", got, 65'h0_5555_AAAA_1234_5678);

        // 6: full FIFO, one-cycle consumer pulse frees exactly one slot a cycle later
        rd_ready = 0; wr_valid = 1;
        for (int k = 0; k < 20 && s_wrdy; k++) begin
            wr_pd = W'(32'hF000 + k);
            cycle();
        end
        cycle();
        chk("t6_full", W'(s_wrdy), W'(0));
        a0 = acc;
        wr_pd = 65'h1_0000_0000_0000_00F6;
        rd_ready = 1;
        cycle();
        chk("t6_no_comb_ready", W'(s_wrdy), W'(0));
        rd_ready = 0;
        cycle();
        chk("t6_ready_next", W'(s_wrdy), W'(1));
        cycle();
        chk("t6_full_again", W'(s_wrdy), W'(0));
        chk("t6_one_accept", W'(acc - a0), W'(1));
        wr_valid = 0; rd_ready = 1;
        for (int k = 0; k < 16; k++) cycle();
        chk("t6_empty", W'(s_idle), W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
